// File: rtl/dsp_wresp_channel.sv
// Per-master AXI4 write-response dispatcher: arbitrates B responses from all slave-side
// arbiters, strips the master-index prefix from BID and drives one registered B stage.
// Define DSP_WRESP_RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
module dsp_wresp_channel #(
    parameter int SLV_AMT         = 2,
    parameter int TRANS_MST_ID_W  = 5,
    parameter int MST_ID_W        = 2,
    parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
    parameter int TRANS_WR_RESP_W = 2
) (
    input  logic                                ACLK_i,
    input  logic                                ARESET_i,
    input  logic [TRANS_SLV_ID_W*SLV_AMT-1:0]   sa_BID_i,
    input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]  sa_BRESP_i,
    input  logic [SLV_AMT-1:0]                  sa_BVALID_i,
    output logic [SLV_AMT-1:0]                  sa_BREADY_o,
    output logic [TRANS_MST_ID_W-1:0]           m_BID_o,
    output logic [TRANS_WR_RESP_W-1:0]          m_BRESP_o,
    output logic                                m_BVALID_o,
    input  logic                                m_BREADY_i
);

    localparam int PTR_W = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1;

    logic                       load_ok;
    logic                       found;
    logic                       grant_vld;
    logic [PTR_W-1:0]           grant_idx;
    logic [TRANS_MST_ID_W-1:0]  sel_id;
    logic [TRANS_WR_RESP_W-1:0] sel_resp;
    logic [MST_ID_W*SLV_AMT-1:0] unused_id_prefix;

    // The output slot may be refilled when empty or when it drains in this same cycle.
    assign load_ok = ~m_BVALID_o | m_BREADY_i;

`ifdef DSP_WRESP_RR_ARB_EN
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cand_idx;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int i = 0; i < SLV_AMT; i++) begin
            cand_idx = PTR_W'((int'(rr_ptr) + i) % SLV_AMT);
            if (!found && sa_BVALID_i[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant_vld = found & load_ok & ~ARESET_i;
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (grant_idx == PTR_W'(SLV_AMT - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < SLV_AMT; i++) begin
            if (!found && sa_BVALID_i[i]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
        grant_vld = found & load_ok & ~ARESET_i;
    end
`endif

    // Granted-slice mux and one-hot ready; the master-index prefix of BID is dropped here.
    always_comb begin
        sel_id           = '0;
        sel_resp         = '0;
        sa_BREADY_o      = '0;
        unused_id_prefix = '0;
        for (int k = 0; k < SLV_AMT; k++) begin
            unused_id_prefix[MST_ID_W*k +: MST_ID_W] =
                sa_BID_i[TRANS_SLV_ID_W*k + TRANS_MST_ID_W +: MST_ID_W];
            if (grant_idx == PTR_W'(k)) begin
                sel_id         = sa_BID_i[TRANS_SLV_ID_W*k +: TRANS_MST_ID_W];
                sel_resp       = sa_BRESP_i[TRANS_WR_RESP_W*k +: TRANS_WR_RESP_W];
                sa_BREADY_o[k] = grant_vld;
            end
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            m_BVALID_o <= 1'b0;
            m_BID_o    <= '0;
            m_BRESP_o  <= '0;
        end else if (grant_vld) begin
            m_BVALID_o <= 1'b1;
            m_BID_o    <= sel_id;
            m_BRESP_o  <= sel_resp;
        end else if (m_BREADY_i) begin
            m_BVALID_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_wresp_channel.sv
// Directed bench for dsp_wresp_channel; expected grant order follows DSP_WRESP_RR_ARB_EN.
module tb_dsp_wresp_channel;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] sa_bid;
    logic [3:0]  sa_bresp;
    logic [1:0]  sa_bvalid;
    logic [1:0]  sa_bready;
    logic [4:0]  m_bid;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] exp_item;
    logic [6:0] held;
    int g;

    dsp_wresp_channel dut (
        .ACLK_i      (clk),
        .ARESET_i    (rst),
        .sa_BID_i    (sa_bid),
        .sa_BRESP_i  (sa_bresp),
        .sa_BVALID_i (sa_bvalid),
        .sa_BREADY_o (sa_bready),
        .m_BID_o     (m_bid),
        .m_BRESP_o   (m_bresp),
        .m_BVALID_o  (m_bvalid),
        .m_BREADY_i  (m_bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slaves(input logic [6:0] bid0, input logic [1:0] resp0,
                                input logic [6:0] bid1, input logic [1:0] resp1,
                                input logic [1:0] vld);
        sa_bid    = {bid1, bid0};
        sa_bresp  = {resp1, resp0};
        sa_bvalid = vld;
    endtask

    initial begin
        rst       = 1'b1;
        m_bready  = 1'b0;
        drive_slaves(7'd0, 2'd0, 7'd0, 2'd0, 2'b00);
        repeat (3) next_cycle();
        check("reset_bvalid", m_bvalid, 1'b0);
        check("reset_bid", m_bid, 5'd0);
        check("reset_bresp", m_bresp, 2'd0);
        rst = 1'b0;

        // Idle after reset release
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check("idle_bvalid", m_bvalid, 1'b0);
            check("idle_bid", m_bid, 5'd0);
            check("idle_bready", sa_bready, 2'b00);
        end

        // Single response from slave 1, prefix 2'b10 stripped
        m_bready = 1'b1;
        drive_slaves(7'd0, 2'd0, 7'b10_00011, 2'b10, 2'b10);
        #1 check("single_bready", sa_bready, 2'b10);
        next_cycle();
        check("single_bvalid", m_bvalid, 1'b1);
        check("single_bid", m_bid, 5'b00011);
        check("single_bresp", m_bresp, 2'b10);
        drive_slaves(7'd0, 2'd0, 7'd0, 2'd0, 2'b00);
        #1 check("single_no_regrant", sa_bready, 2'b00);
        next_cycle();
        check("single_drained", m_bvalid, 1'b0);

        // Contention, both slaves valid, one response per cycle
        drive_slaves(7'b01_00101, 2'b01, 7'b11_01010, 2'b11, 2'b11);
        for (int i = 0; i < 6; i++) begin
`ifdef DSP_WRESP_RR_ARB_EN
            g = i % 2;
`else
            g = 0;
`endif
            exp_q.push_back((g == 0) ? {5'b00101, 2'b01} : {5'b01010, 2'b11});
            #1 check("cont_bready", sa_bready, (g == 0) ? 2'b01 : 2'b10);
            next_cycle();
            exp_item = exp_q.pop_front();
            check("cont_bvalid", m_bvalid, 1'b1);
            check("cont_bid", m_bid, exp_item[6:2]);
            check("cont_bresp", m_bresp, exp_item[1:0]);
        end
`ifdef DSP_WRESP_RR_ARB_EN
        held = {5'b01010, 2'b11};
`else
        held = {5'b00101, 2'b01};
`endif

        // Backpressure: output holds, no grants
        m_bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_bready", sa_bready, 2'b00);
            next_cycle();
            check("bp_bvalid", m_bvalid, 1'b1);
            check("bp_bid", m_bid, held[6:2]);
            check("bp_bresp", m_bresp, held[1:0]);
        end
        // Release: drain and refill in the same edge; slave 0 is next either way
        m_bready = 1'b1;
        #1 check("bp_release_bready", sa_bready, 2'b01);
        next_cycle();
        check("bp_release_bvalid", m_bvalid, 1'b1);
        check("bp_release_bid", m_bid, 5'b00101);
        check("bp_release_bresp", m_bresp, 2'b01);

        // Leave slave 0 as the last winner, then reset while stalled
        drive_slaves(7'b01_00101, 2'b01, 7'b11_01010, 2'b11, 2'b01);
        #1 check("pre_rst_bready", sa_bready, 2'b01);
        next_cycle();
        check("pre_rst_bid", m_bid, 5'b00101);
        m_bready = 1'b0;
        rst      = 1'b1;
        drive_slaves(7'b01_00101, 2'b01, 7'b11_01010, 2'b11, 2'b11);
        #1 check("rst_mid_bready", sa_bready, 2'b00);
        next_cycle();
        check("rst_mid_bvalid", m_bvalid, 1'b0);
        check("rst_mid_bid", m_bid, 5'd0);
        check("rst_mid_bresp", m_bresp, 2'd0);
        m_bready = 1'b1;
        #1 check("rst_hold_bready", sa_bready, 2'b00);
        next_cycle();
        check("rst_hold_bvalid", m_bvalid, 1'b0);
        rst = 1'b0;
        #1 check("post_rst_bready", sa_bready, 2'b01);
        next_cycle();
        check("post_rst_bvalid", m_bvalid, 1'b1);
        check("post_rst_bid", m_bid, 5'b00101);
        check("post_rst_bresp", m_bresp, 2'b01);

        drive_slaves(7'd0, 2'd0, 7'd0, 2'd0, 2'b00);
        next_cycle();
        check("final_drain", m_bvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_wresp_channel.md
# dsp_wresp_channel

Per-master write-response dispatcher that sits directly downstream of the slave-side write-response arbiters. It collects B responses addressed to one master from all `SLV_AMT` slave-side arbiters and arbitrates among them. It strips the interconnect master-ID prefix from `BID` and drives the master's AXI4 B channel through a single registered output stage. One instance exists per master port.

## Interface
Parameters:
- `SLV_AMT`, 2, number of slave-side write-response arbiters feeding this master.
- `TRANS_MST_ID_W`, 5, width of the master-side transaction ID.
- `MST_ID_W`, 2, width of the master-index prefix prepended by the interconnect.
- `TRANS_SLV_ID_W`, `TRANS_MST_ID_W + MST_ID_W`, width of the slave-side transaction ID.
- `TRANS_WR_RESP_W`, 2, BRESP width.

Ports (one clock; reset is synchronous and active-high):
- `ACLK_i`  in  1  clock; all state updates on the rising edge.
- `ARESET_i`  in  1  synchronous active-high reset.
- `sa_BID_i`  in  `TRANS_SLV_ID_W*SLV_AMT`  BID per slave arbiter; slice k = `[TRANS_SLV_ID_W*(k+1)-1 -: TRANS_SLV_ID_W]`.
- `sa_BRESP_i`  in  `TRANS_WR_RESP_W*SLV_AMT`  BRESP per slave arbiter, same slicing.
- `sa_BVALID_i`  in  `SLV_AMT`  response valid per slave arbiter.
- `sa_BREADY_o`  out  `SLV_AMT`  ready back to each slave arbiter.
- `m_BID_o`  out  `TRANS_MST_ID_W`  master-side BID.
- `m_BRESP_o`  out  `TRANS_WR_RESP_W`  master-side BRESP.
- `m_BVALID_o`  out  1  master-side valid.
- `m_BREADY_i`  in  1  master-side ready.

## Operation
- Output stage: one register holding {BID, BRESP}, plus a valid flag that drives `m_BVALID_o`.
- `load_ok = ~m_BVALID_o | m_BREADY_i`.
  - When `load_ok` is high and any `sa_BVALID_i` bit is set, the arbiter picks grant index g.
  - `sa_BREADY_o[g]=1` combinationally in that cycle; all other bits are 0.
  - `sa_BREADY_o` is all-zero when `load_ok` is low or no request is present.
- `sa_BREADY_o` is one-hot or zero at all times.
- `sa_BREADY_o` may depend combinationally on `sa_BVALID_i` and `m_BREADY_i`. It never depends on upstream ready.
- On a grant at the clock edge:
  - `m_BID_o <= sa_BID_i[g][TRANS_MST_ID_W-1:0]`.
  - `m_BRESP_o <= sa_BRESP_i[g]`.
  - `m_BVALID_o <= 1`.
  - The upper `MST_ID_W` bits of BID are discarded.
- Without a grant: if `m_BVALID_o & m_BREADY_i`, then `m_BVALID_o <= 0`. Otherwise the register holds.
- While `m_BVALID_o=1` and `m_BREADY_i=0`, `m_BID_o` and `m_BRESP_o` stay stable (AXI rule).
- Arbiter, round-robin:
  - Pointer `rr_ptr` (width `$clog2(SLV_AMT)`, minimum 1) holds the highest-priority index.
  - Search order: `rr_ptr`, `rr_ptr+1`, …, wrapping modulo `SLV_AMT`.
  - On a grant to g, `rr_ptr <= (g==SLV_AMT-1) ? 0 : g+1`.
  - Without a grant the pointer holds.
- Reset (any cycle, including mid-transfer):
  - `m_BVALID_o=0`, `m_BID_o=0`, `m_BRESP_o=0`, `rr_ptr=0`.
  - Any held response is dropped; upstream is reset in the same cycle.
  - `sa_BREADY_o=0` while `ARESET_i=1`.

## Timing
- Latency: an upstream handshake in cycle N gives `m_BVALID_o=1` in cycle N+1.
- Throughput: one response per cycle with `m_BREADY_i` held high. Back-to-back grants are allowed because `load_ok` includes the same-cycle drain.
- Simultaneous drain and load: the new response replaces the old one in the same edge, and `m_BVALID_o` stays 1.
- Backpressure: with `m_BVALID_o=1` and `m_BREADY_i=0`, no grant is issued and every `sa_BREADY_o` bit is 0.
- No other pipeline stages; no FIFO.

## Configuration
- `DSP_WRESP_RR_ARB_EN` defined: round-robin arbitration as above.
- `DSP_WRESP_RR_ARB_EN` undefined: fixed priority, lowest index wins. `rr_ptr` is not implemented. All other behaviour is identical.

## Test plan
- Reset release, no traffic: `m_BVALID_o=0`, `m_BID_o=0`, `sa_BREADY_o=0` for 10 cycles.
- Single response: slave 1 presents BID=7'b10_00011, BRESP=2'b10 with `m_BREADY_i=1`.
  - `sa_BREADY_o=2'b10` in cycle N.
  - `m_BID_o=5'b00011`, `m_BRESP_o=2'b10`, `m_BVALID_o=1` in cycle N+1.
- Contention, RR enabled: both slaves valid continuously with `m_BREADY_i=1`. Grants alternate 0,1,0,1. The output BID sequence matches, one response per cycle.
- Contention, macro undefined: same stimulus. Slave 0 is granted every cycle and slave 1 is starved.
- Backpressure: `m_BREADY_i=0` for 5 cycles with both slaves valid.
  - `m_BID_o`/`m_BRESP_o` stay stable and `sa_BREADY_o=0`.
  - `m_BREADY_i` rises → drain, and the next grant occurs in the same cycle.
- Reset mid-transfer: `ARESET_i=1` while `m_BVALID_o=1` and `m_BREADY_i=0`.
  - Next cycle: `m_BVALID_o=0`, outputs zero.
  - After release, slave 0 gets first priority.
